// File: rtl/datapath_pkg.sv
// Shared types for the scratchpad request arbiter.
// Build option: SP_ARB_RR_EN selects round-robin arbitration.
package datapath_pkg;

  parameter int SP_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    SP_SRC_MLS  = 1'b0,
    SP_SRC_GEMM = 1'b1
  } sp_src_t;

  typedef struct packed {
    logic        ls_out;
    logic [3:0]  rd_out;
    logic [31:0] address;
    logic [31:0] stride_out;
    logic        done;
  } matrix_ls_t;

  typedef struct packed {
    logic [3:0] md;
    logic [3:0] ms1;
    logic [3:0] ms2;
  } fu_gemm_t;

  typedef struct packed {
    sp_src_t    src;
    matrix_ls_t mls;
    fu_gemm_t   gemm;
    logic       new_weight;
  } sp_req_t;

  function automatic matrix_ls_t strip_done(
    input matrix_ls_t r
  );
    matrix_ls_t t;
    t      = r;
    t.done = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/sp_req_arbiter_if.sv
// FU-side and scratchpad-side signals of the scratchpad arbiter.
// Build option: SP_ARB_RR_EN (no effect on this interface).
interface sp_req_arbiter_if;
  import datapath_pkg::*;

  logic       mls_valid;
  matrix_ls_t mls_req;
  logic       mls_ready;
  logic       gemm_valid;
  fu_gemm_t   gemm_req;
  logic       gemm_new_weight;
  logic       gemm_ready;
  logic       sp_valid;
  logic       sp_ready;
  sp_src_t    sp_src;
  matrix_ls_t sp_mls;
  fu_gemm_t   sp_gemm;
  logic       sp_new_weight;
  logic       sp_done;
  logic       mls_done;
  logic       gemm_done;
  logic       busy;

  modport master (
    output mls_valid,
    output mls_req,
    output gemm_valid,
    output gemm_req,
    output gemm_new_weight,
    output sp_ready,
    output sp_done,
    input  mls_ready,
    input  gemm_ready,
    input  sp_valid,
    input  sp_src,
    input  sp_mls,
    input  sp_gemm,
    input  sp_new_weight,
    input  mls_done,
    input  gemm_done,
    input  busy
  );

  modport slave (
    input  mls_valid,
    input  mls_req,
    input  gemm_valid,
    input  gemm_req,
    input  gemm_new_weight,
    input  sp_ready,
    input  sp_done,
    output mls_ready,
    output gemm_ready,
    output sp_valid,
    output sp_src,
    output sp_mls,
    output sp_gemm,
    output sp_new_weight,
    output mls_done,
    output gemm_done,
    output busy
  );

endinterface

// File: rtl/sp_req_arbiter_grant.sv
// Combinational grant plus priority state for the scratchpad arbiter.
// SP_ARB_RR_EN: round-robin pointer; otherwise GEMM-first with starvation guard.
module sp_grant_logic
  import datapath_pkg::*;
#(
  parameter int STARVE_MAX = SP_STARVE_MAX
) (
  input  logic CLK,
  input  logic nRST,
  input  logic idle,
  input  logic mls_valid,
  input  logic gemm_valid,
  output logic grant_mls,
  output logic grant_gemm
);

  logic mls_first;

`ifdef SP_ARB_RR_EN
  sp_src_t ptr;

  assign mls_first = (ptr == SP_SRC_MLS);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr <= SP_SRC_MLS;
    end else if (grant_mls) begin
      ptr <= SP_SRC_GEMM;
    end else if (grant_gemm) begin
      ptr <= SP_SRC_MLS;
    end
  end
`else
  logic [2:0] starve_cnt;

  assign mls_first = ({29'd0, starve_cnt} >= STARVE_MAX);

  // Only GEMM wins that left MLS waiting count toward starvation.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (grant_mls) begin
      starve_cnt <= '0;
    end else if (grant_gemm) begin
      if (!mls_valid) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`endif

  assign grant_mls = idle && mls_valid
                  && (!gemm_valid || mls_first);
  assign grant_gemm = idle && gemm_valid
                   && !grant_mls;

endmodule

// File: rtl/sp_req_arbiter.sv
// Single-owner arbiter between the MLS and GEMM FUs and the scratchpad port.
// Build option: SP_ARB_RR_EN selects round-robin grant (see sp_grant_logic).
module sp_req_arbiter
  import datapath_pkg::*;
#(
  parameter int STARVE_MAX = SP_STARVE_MAX
) (
  input logic        CLK,
  input logic        nRST,
  sp_req_arbiter_if.slave bus
);

  arb_state_e state;
  sp_req_t    req_q;
  logic       sp_valid_q;
  logic       mls_done_q;
  logic       gemm_done_q;
  logic       idle;
  logic       grant_mls;
  logic       grant_gemm;

  assign idle = (state == ARB_IDLE);

  sp_grant_logic #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .CLK        (CLK),
    .nRST       (nRST),
    .idle       (idle),
    .mls_valid  (bus.mls_valid),
    .gemm_valid (bus.gemm_valid),
    .grant_mls  (grant_mls),
    .grant_gemm (grant_gemm)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= ARB_IDLE;
      req_q       <= '0;
      sp_valid_q  <= 1'b0;
      mls_done_q  <= 1'b0;
      gemm_done_q <= 1'b0;
    end else begin
      mls_done_q  <= 1'b0;
      gemm_done_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_mls || grant_gemm) begin
            req_q.src  <= grant_gemm ? SP_SRC_GEMM
                                     : SP_SRC_MLS;
            sp_valid_q <= 1'b1;
            state      <= ARB_REQ;
          end
          if (grant_mls) begin
            req_q.mls <= strip_done(bus.mls_req);
          end
          if (grant_gemm) begin
            req_q.gemm       <= bus.gemm_req;
            req_q.new_weight <= bus.gemm_new_weight;
          end
        end
        ARB_REQ: begin
          if (bus.sp_ready) begin
            sp_valid_q <= 1'b0;
            state      <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.sp_done) begin
            mls_done_q  <= (req_q.src == SP_SRC_MLS);
            gemm_done_q <= (req_q.src == SP_SRC_GEMM);
            state       <= ARB_IDLE;
          end
        end
        default: begin
          sp_valid_q <= 1'b0;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.mls_ready     = grant_mls;
  assign bus.gemm_ready    = grant_gemm;
  assign bus.sp_valid      = sp_valid_q;
  assign bus.sp_src        = req_q.src;
  assign bus.sp_mls        = req_q.mls;
  assign bus.sp_gemm       = req_q.gemm;
  assign bus.sp_new_weight = req_q.new_weight;
  assign bus.mls_done      = mls_done_q;
  assign bus.gemm_done     = gemm_done_q;
  assign bus.busy          = !idle;

endmodule
